vvp_acc: RTL and testbench

- Bit-serial accumulator that sits directly downstream of the vvp dot-product tree.
- Each cycle it consumes one signed partial sum S, produced from one weight bit-plane × one data crumb-plane.
- It shifts the partial sum by its plane significance and adds it into a wide accumulator.
- After the last plane it emits one saturated result through a valid/ready output register.

---
 rtl/mvu_pkg.sv | 11 +
 rtl/vvp_acc_sat.sv | 14 +
 rtl/vvp_acc.sv | 69 ++++++
 tb/tb_vvp_acc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// mvu_pkg: shared widths, accumulator state encoding and output clamp limits
package mvu_pkg;
  localparam int N   = 64;
  localparam int SW  = $clog2(N) + 2;
  localparam int AW  = 32;
  localparam int OW  = 16;
  localparam int SHW = 5;
  localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};
  typedef enum logic {IDLE, ACC} state_t;
endpackage

// File: rtl/vvp_acc_sat.sv
// vvp_acc_sat: narrows the wide accumulator to the output width, clamping or truncating
module vvp_acc_sat #(
  parameter int AW  = mvu_pkg::AW,
  parameter int OW  = mvu_pkg::OW,
  parameter bit SAT = 1'b1
) (
  input  logic [AW-1:0] r,
  output logic [OW-1:0] data,
  output logic          sat
);
  // r fits in OW bits exactly when every bit from the OW sign position up agrees
  assign sat  = SAT && !((&r[AW-1:OW-1]) || !(|r[AW-1:OW-1]));
  assign data = sat ? {r[AW-1], {(OW-1){~r[AW-1]}}} : r[OW-1:0];
endmodule

// File: rtl/vvp_acc.sv
// vvp_acc: bit-serial plane accumulator behind the vvp dot-product tree,
// emitting one saturated result per accumulation through a valid/ready register
module vvp_acc
  import mvu_pkg::*;
#(
  parameter int N   = mvu_pkg::N,
  parameter int SW  = $clog2(N) + 2,
  parameter int AW  = mvu_pkg::AW,
  parameter int OW  = mvu_pkg::OW,
  parameter int SHW = mvu_pkg::SHW,
  parameter bit SAT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SW-1:0]  in_s,
  input  logic [SHW-1:0] in_shift,
  input  logic           in_first,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_data,
  output logic           out_sat
);
  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, term;
  logic          out_valid_q, out_valid_d, out_sat_q, out_sat_d, sat_flag, take, fin;
  logic [OW-1:0] out_data_q, out_data_d, sat_data;

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    take        = in_valid && in_ready;
    fin         = take && in_last;
    term        = {{(AW-SW){in_s[SW-1]}}, in_s} << in_shift;
    acc_d       = !take ? acc_q : (state_q == IDLE || in_first) ? term : acc_q + term;
    state_d     = !take ? state_q : in_last ? IDLE : ACC;
    out_valid_d = fin || (out_valid_q && !out_ready);
    out_data_d  = fin ? sat_data : out_data_q;
    out_sat_d   = fin ? sat_flag : out_sat_q;
  end

  // the clamp sees the post-beat value so the result lands one edge after the last beat
  vvp_acc_sat #(.AW(AW), .OW(OW), .SAT(SAT)) u_sat (
    .r    (acc_d),
    .data (sat_data),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_vvp_acc.sv
// tb_vvp_acc: directed vector table plus hand sequences for backpressure, back-to-back and reset
module tb_vvp_acc;
  import mvu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_s = '0;
  logic [4:0]  in_shift = '0;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    int s;
    int sh;
    bit f;
    bit l;
    int d;
    bit sat;
  } vec_t;
  vec_t tbl[$];

  vvp_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_shift  (in_shift),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int s, input int sh, input bit f, input bit l, input int d, input bit sat);
    vec_t v;
    v = '{s: s, sh: sh, f: f, l: l, d: d, sat: sat};
    tbl.push_back(v);
  endtask

  task automatic beat(input int s, input int sh, input bit f, input bit l);
    @(negedge clk);
    in_valid = 1'b1;
    in_s     = 8'(s);
    in_shift = 5'(sh);
    in_first = f;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    add(-64, 0, 1, 1, -64, 0);
    add(3, 0, 1, 0, 0, 0);
    add(-2, 1, 0, 0, 0, 0);
    add(1, 2, 0, 1, 3, 0);
    add(64, 10, 1, 1, int'(OUT_MAX), 1);
    add(-64, 10, 1, 1, int'(OUT_MIN), 1);
    add(64, 8, 1, 0, 0, 0);
    add(-64, 8, 0, 1, 0, 0);
    add(10, 0, 1, 0, 0, 0);
    add(20, 0, 0, 0, 0, 0);
    add(7, 0, 1, 1, 7, 0);
    add(127, 8, 1, 0, 0, 0);
    add(127, 0, 0, 0, 0, 0);
    add(127, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 32767, 0);
    add(-128, 8, 1, 1, -32768, 0);
    add(-128, 8, 1, 0, 0, 0);
    add(-1, 0, 0, 1, int'(OUT_MIN), 1);
    add(1, 31, 1, 1, int'(OUT_MIN), 1);
    add(64, 25, 1, 0, 0, 0);
    add(64, 25, 0, 1, 0, 0);
    add(5, 0, 0, 0, 0, 0);
    add(2, 0, 0, 1, 7, 0);

    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", $signed(out_data), 0);
    chk("rst_sat", 32'(out_sat), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (i % 2 == 1) @(posedge clk);
      beat(tbl[i].s, tbl[i].sh, tbl[i].f, tbl[i].l);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].l));
      if (tbl[i].l) begin
        chk($sformatf("tbl%0d_data", i), $signed(out_data), tbl[i].d);
        chk($sformatf("tbl%0d_sat", i), 32'(out_sat), 32'(tbl[i].sat));
      end
    end

    // back-to-back single-beat accumulations, one per cycle
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_shift = '0;
    for (int k = 0; k < 3; k++) begin
      in_s = 8'(11 + k);
      @(posedge clk);
      #1;
      chk("b2b_valid", 32'(out_valid), 1);
      chk("b2b_data", $signed(out_data), 11 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // backpressure: held result, beats refused, then refill on the draining edge
    beat(9, 0, 1, 1);
    out_ready = 1'b0;
    chk("bp_first", $signed(out_data), 9);
    @(negedge clk);
    in_valid = 1'b1; in_s = 8'(100); in_first = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", $signed(out_data), 9);
    end
    @(negedge clk);
    in_s = 8'(5);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_refill_valid", 32'(out_valid), 1);
    chk("bp_refill_data", $signed(out_data), 5);
    @(posedge clk);
    #1;
    chk("bp_drain_valid", 32'(out_valid), 0);

    // asynchronous reset mid-accumulation; a non-first beat must then start fresh
    beat(50, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 0, 0, 1);
    chk("rst_mid_after", $signed(out_data), 1);
    chk("rst_mid_after_valid", 32'(out_valid), 1);

    // asynchronous reset while a result is being held
    beat(4, 0, 1, 1);
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(out_valid), 0);
    chk("rst_hold_data", $signed(out_data), 0);
    chk("rst_hold_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(1, 0, 1, 1);
    chk("rst_hold_after", $signed(out_data), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
